lzd_norm_pipe: RTL and testbench

LZD_NORM_PIPE -- requirements
Module: lzd_norm_pipe

---
 rtl/lzd_pkg.sv | 17 +
 rtl/lzd_tree.sv | 45 ++++
 rtl/lzd_norm_pipe.sv | 98 +++++++++
 tb/tb_lzd_norm_pipe.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lzd_pkg.sv
// Shared definitions for the leading-zero/one detect and normalise pipeline.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package lzd_pkg;

    // Polarity of the leading run being counted.
    typedef enum logic {
        LZ_MODE_ZERO = 1'b0,
        LZ_MODE_ONE  = 1'b1
    } lz_mode_e;

    // Count must represent 0..w inclusive, so one bit more than log2(w).
    function automatic int count_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/lzd_tree.sv
// Combinational leading-zero detector built as a recursive halving tree.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; count is meaningful only when valid=1 (some bit set).
module lzd_tree #(
    parameter int W = 32
) (
    input  logic [W-1:0]         data,
    output logic [$clog2(W)-1:0] count,
    output logic                 valid
);

    generate
        if (W == 2) begin : g_leaf
            // Two-bit leaf: one leading zero exactly when the upper bit is clear.
            assign valid = data[1] | data[0];
            assign count = ~data[1];
        end else begin : g_node
            localparam int HW  = W / 2;
            localparam int HCW = $clog2(HW);

            logic [HCW-1:0] cnt_hi;
            logic [HCW-1:0] cnt_lo;
            logic           vld_hi;
            logic           vld_lo;

            lzd_tree #(.W(HW)) u_hi (
                .data  (data[W-1:HW]),
                .count (cnt_hi),
                .valid (vld_hi)
            );

            lzd_tree #(.W(HW)) u_lo (
                .data  (data[HW-1:0]),
                .count (cnt_lo),
                .valid (vld_lo)
            );

            // An empty upper half contributes HW zeros (the inverted valid as MSB)
            // and the lower half supplies the remaining bits.
            assign valid = vld_hi | vld_lo;
            assign count = {~vld_hi, (vld_hi ? cnt_hi : cnt_lo)};
        end
    endgenerate

endmodule

// File: rtl/lzd_norm_pipe.sv
// Leading zero/one count plus left-normalise, two-stage valid/ready pipeline.
// Latency: 2 cycles from input transfer to out_valid; one result per cycle.
// Backpressure: stages hold under out_ready=0, bubbles collapse, in_ready drops once both stages are full.
module lzd_norm_pipe
    import lzd_pkg::*;
#(
    parameter  int W  = 32,
    localparam int CW = count_width(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_count,
    output logic          out_found,
    output logic [W-1:0]  out_norm
);

    logic [W-1:0]  search;
    logic [CW-2:0] tree_cnt;
    logic          tree_vld;
    logic [CW-1:0] in_cnt;

    logic          s1_vld;
    logic [W-1:0]  s1_data;
    lz_mode_e      s1_mode;
    logic [CW-1:0] s1_cnt;

    logic          s1_load;
    logic          s2_load;
    logic          s1_found;
    logic [W-1:0]  s1_norm;

    // Counting leading ones is counting leading zeros of the inverted word.
    assign search = in_data ^ {W{in_mode}};

    lzd_tree #(.W(W)) u_tree (
        .data  (search),
        .count (tree_cnt),
        .valid (tree_vld)
    );

    // An all-polarity operand has no differing bit: report the full width.
    assign in_cnt = tree_vld ? {1'b0, tree_cnt} : CW'(W);

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_vld || s2_load;
    assign in_ready = s1_load;

    // Normalise the S1 operand; count==W is the only value with the MSB set.
    always_comb begin
        s1_found = !s1_cnt[CW-1];
        if (s1_mode == LZ_MODE_ONE) begin
            s1_norm = ~((~s1_data) << s1_cnt);
        end else begin
            s1_norm = s1_data << s1_cnt;
        end
    end

    // Stage 1: capture operand, mode and count whenever the stage can advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
            s1_mode <= LZ_MODE_ZERO;
            s1_cnt  <= '0;
        end else if (s1_load) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_mode <= lz_mode_e'(in_mode);
                s1_cnt  <= in_cnt;
            end
        end
    end

    // Stage 2: result registers, held stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_count <= '0;
            out_found <= 1'b0;
            out_norm  <= '0;
        end else if (s2_load) begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                out_count <= s1_cnt;
                out_found <= s1_found;
                out_norm  <= s1_norm;
            end
        end
    end

endmodule

// File: tb/tb_lzd_norm_pipe.sv
// Bench for lzd_norm_pipe at W=32, W=8 and W=64 against a bit-walking model.
// Latency: n/a.
// Backpressure: n/a.
module tb_lzd_norm_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        in_mode;
    logic [63:0] in_data;
    int          sel;

    logic [2:0]  iv;
    logic [2:0]  ordy;
    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [2:0]  fnd;
    logic [5:0]  cnt32;
    logic [3:0]  cnt8;
    logic [6:0]  cnt64;
    logic [31:0] norm32;
    logic [7:0]  norm8;
    logic [63:0] norm64;

    logic        o_vld;
    logic        o_rdy;
    logic        o_found;
    int          o_cnt;
    logic [63:0] o_norm;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Only the selected instance sees traffic; the others idle and drain.
    assign iv[0]   = in_valid && (sel == 0);
    assign iv[1]   = in_valid && (sel == 1);
    assign iv[2]   = in_valid && (sel == 2);
    assign ordy[0] = (sel == 0) ? out_ready : 1'b1;
    assign ordy[1] = (sel == 1) ? out_ready : 1'b1;
    assign ordy[2] = (sel == 2) ? out_ready : 1'b1;

    lzd_norm_pipe #(.W(32)) u_w32 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(in_data[31:0]), .in_mode(in_mode), .out_valid(ov[0]),
        .out_ready(ordy[0]), .out_count(cnt32), .out_found(fnd[0]), .out_norm(norm32)
    );

    lzd_norm_pipe #(.W(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(in_data[7:0]), .in_mode(in_mode), .out_valid(ov[1]),
        .out_ready(ordy[1]), .out_count(cnt8), .out_found(fnd[1]), .out_norm(norm8)
    );

    lzd_norm_pipe #(.W(64)) u_w64 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(in_data), .in_mode(in_mode), .out_valid(ov[2]),
        .out_ready(ordy[2]), .out_count(cnt64), .out_found(fnd[2]), .out_norm(norm64)
    );

    // Present the selected instance's outputs in a common 64-bit view.
    always_comb begin
        o_vld   = ov[0];
        o_rdy   = ir[0];
        o_found = fnd[0];
        o_cnt   = {26'd0, cnt32};
        o_norm  = {32'd0, norm32};
        case (sel)
            1: begin
                o_vld = ov[1]; o_rdy = ir[1]; o_found = fnd[1];
                o_cnt = {28'd0, cnt8}; o_norm = {56'd0, norm8};
            end
            2: begin
                o_vld = ov[2]; o_rdy = ir[2]; o_found = fnd[2];
                o_cnt = {25'd0, cnt64}; o_norm = norm64;
            end
            default: ;
        endcase
    end

    function automatic int width_of(input int k);
        case (k)
            1:       return 8;
            2:       return 64;
            default: return 32;
        endcase
    endfunction

    function automatic logic [63:0] mask_of(input int w);
        return ~64'd0 >> (64 - w);
    endfunction

    // Walk from the MSB while bits match the polarity.
    function automatic int ref_cnt(input logic [63:0] d, input int w, input bit m);
        int c = 0;
        for (int i = w - 1; i >= 0; i--) begin
            if (d[i] != m) break;
            c++;
        end
        return c;
    endfunction

    // Bit i of the result comes from bit i-c of the operand, else the fill value.
    function automatic logic [63:0] ref_norm(input logic [63:0] d, input int w,
                                             input bit m, input int c);
        logic [63:0] r = '0;
        for (int i = 0; i < w; i++) begin
            if (i >= c) r[i] = d[i - c];
            else        r[i] = m;
        end
        return r;
    endfunction

    // Random operand with a random-length leading run of the mode polarity.
    function automatic logic [63:0] gen_data(input int w, input bit m);
        logic [63:0] r;
        int sh;
        r  = {$urandom, $urandom} & mask_of(w);
        sh = $urandom_range(0, w);
        r  = r >> sh;
        if (m) r = ~r & mask_of(w);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int seen = 0;
        sel = 0; rst = 1'b1; in_valid = 1'b1; in_data = 64'h8000; in_mode = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        checks++; if (ov !== 3'b000) begin errors++; $display("FAIL reset_valid: got %b expected 000", ov); end
        checks++; if (cnt32 !== 6'd0) begin errors++; $display("FAIL reset_cnt32: got %0d expected 0", cnt32); end
        checks++; if (cnt8 !== 4'd0) begin errors++; $display("FAIL reset_cnt8: got %0d expected 0", cnt8); end
        checks++; if (cnt64 !== 7'd0) begin errors++; $display("FAIL reset_cnt64: got %0d expected 0", cnt64); end
        checks++; if (fnd !== 3'b000) begin errors++; $display("FAIL reset_found: got %b expected 000", fnd); end
        checks++; if (norm32 !== 32'd0) begin errors++; $display("FAIL reset_norm32: got %h expected 0", norm32); end
        checks++; if (norm8 !== 8'd0) begin errors++; $display("FAIL reset_norm8: got %h expected 0", norm8); end
        checks++; if (norm64 !== 64'd0) begin errors++; $display("FAIL reset_norm64: got %h expected 0", norm64); end
        step();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++; if (ir !== 3'b111) begin errors++; $display("FAIL ready_after_reset: got %b expected 111", ir); end
        repeat (5) begin
            @(negedge clk);
            if (ov !== 3'b000) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL reset_offer_ignored: got %0d outputs expected 0", seen); end
        step();
    endtask

    task automatic test_directed();
        logic [31:0] d_tab[5] = '{32'h0000_8000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFF0_1234, 32'h0000_0001};
        bit          m_tab[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int          c_tab[5] = '{16, 32, 32, 12, 31};
        bit          f_tab[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] n_tab[5] = '{32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0123_4FFF, 32'h8000_0000};
        int lat;
        sel = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            out_ready = 1'b1; in_valid = 1'b1;
            in_data = {32'd0, d_tab[i]}; in_mode = m_tab[i];
            lat = 0;
            for (int e = 1; e <= 6; e++) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                if (o_vld === 1'b1) begin lat = e; break; end
            end
            checks++; if (lat != 2) begin errors++; $display("FAIL dir%0d_latency: got %0d expected 2", i, lat); end
            checks++; if (o_cnt !== c_tab[i]) begin errors++; $display("FAIL dir%0d_count: got %0d expected %0d", i, o_cnt, c_tab[i]); end
            checks++; if (o_found !== f_tab[i]) begin errors++; $display("FAIL dir%0d_found: got %b expected %b", i, o_found, f_tab[i]); end
            checks++; if (o_norm !== {32'd0, n_tab[i]}) begin errors++; $display("FAIL dir%0d_norm: got %h expected %h", i, o_norm, n_tab[i]); end
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [63:0] hist[14];
        bit exp_v;
        int e_c;
        sel = 0;
        step();
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 10); in_mode = 1'b0; out_ready = 1'b1;
            in_data = 64'h1 << (3 * c);
            hist[c] = in_data & mask_of(32);
            @(negedge clk);
            exp_v = (c >= 2) && (c < 12);
            checks++; if (o_vld !== exp_v) begin errors++; $display("FAIL b2b_valid_c%0d: got %b expected %b", c, o_vld, exp_v); end
            checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL b2b_ready_c%0d: got %b expected 1", c, o_rdy); end
            if (exp_v) begin
                e_c = ref_cnt(hist[c - 2], 32, 1'b0);
                checks++; if (o_cnt !== e_c) begin errors++; $display("FAIL b2b_count_c%0d: got %0d expected %0d", c, o_cnt, e_c); end
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stall();
        logic [63:0] acc[$];
        sel = 0;
        step();
        in_valid = 1'b1; out_ready = 1'b0; in_mode = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_data = 64'h1 << (c + 3);
            @(negedge clk);
            if (o_rdy === 1'b1) acc.push_back(in_data);
            step();
        end
        @(negedge clk);
        checks++; if (acc.size() != 2) begin errors++; $display("FAIL stall_accepted: got %0d expected 2", acc.size()); end
        checks++; if (o_rdy !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", o_rdy); end
        checks++; if (o_vld !== 1'b1) begin errors++; $display("FAIL stall_out_valid: got %b expected 1", o_vld); end
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        if (acc.size() == 2) begin
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                checks++; if (o_vld !== 1'b1) begin errors++; $display("FAIL stall_release%0d_valid: got %b expected 1", k, o_vld); end
                checks++; if (o_cnt !== ref_cnt(acc[k], 32, 1'b0)) begin
                    errors++; $display("FAIL stall_release%0d_count: got %0d expected %0d", k, o_cnt, ref_cnt(acc[k], 32, 1'b0));
                end
                step();
            end
        end
        @(negedge clk);
        checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL stall_drained: got %b expected 0", o_vld); end
        step();
    endtask

    // kind 0: random operands, random valid/ready; kind 1: walking one, ready toggling.
    task automatic test_stream(input int k, input int kind, input int n);
        int          w = width_of(k);
        int          q_cnt[$];
        bit          q_fnd[$];
        logic [63:0] q_norm[$];
        int issued = 0, got = 0, cyc = 0, extra = 0, c, e_c;
        bit pending = 1'b0, held = 1'b0, cur_m = 1'b0, e_f, h_fnd = 1'b0;
        logic [63:0] cur = '0, e_n, h_norm = '0;
        int h_cnt = 0;
        sel = k;
        step();
        while (got < n && cyc < n * 8 + 100) begin
            if (!pending && issued < n) begin
                cur_m = (kind == 1) ? 1'b0 : 1'($urandom_range(0, 1));
                cur = (kind == 1) ? (64'h1 << issued) : gen_data(w, cur_m);
                pending = 1'b1;
            end
            in_valid  = pending && ((kind == 1) || ($urandom_range(0, 3) != 0));
            in_data   = cur | (~mask_of(w) & {$urandom, $urandom});
            in_mode   = cur_m;
            out_ready = (kind == 1) ? ((cyc % 2) == 0) : ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (held) begin
                checks++;
                if (o_vld !== 1'b1 || o_cnt !== h_cnt || o_found !== h_fnd || o_norm !== h_norm) begin
                    errors++; $display("FAIL w%0d_hold: got cnt=%0d norm=%h expected cnt=%0d norm=%h", w, o_cnt, o_norm, h_cnt, h_norm);
                end
                held = 1'b0;
            end
            if (o_vld === 1'b1) begin
                if (out_ready) begin
                    if (q_cnt.size() == 0) begin
                        checks++; errors++; $display("FAIL w%0d_spurious: got output cnt=%0d expected none", w, o_cnt);
                    end else begin
                        e_c = q_cnt.pop_front(); e_f = q_fnd.pop_front(); e_n = q_norm.pop_front();
                        checks++; if (o_cnt !== e_c) begin errors++; $display("FAIL w%0d_count#%0d: got %0d expected %0d", w, got, o_cnt, e_c); end
                        checks++; if (o_found !== e_f) begin errors++; $display("FAIL w%0d_found#%0d: got %b expected %b", w, got, o_found, e_f); end
                        checks++; if (o_norm !== e_n) begin errors++; $display("FAIL w%0d_norm#%0d: got %h expected %h", w, got, o_norm, e_n); end
                        if (kind == 1) begin
                            checks++; if (o_cnt !== w - 1 - got) begin errors++; $display("FAIL walk_order#%0d: got %0d expected %0d", got, o_cnt, w - 1 - got); end
                        end
                        got++;
                    end
                end else begin
                    held = 1'b1; h_cnt = o_cnt; h_fnd = o_found; h_norm = o_norm;
                end
            end
            if (in_valid && o_rdy === 1'b1) begin
                c = ref_cnt(cur, w, cur_m);
                q_cnt.push_back(c);
                q_fnd.push_back(c < w);
                q_norm.push_back(ref_norm(cur, w, cur_m, c));
                issued++;
                pending = 1'b0;
            end
            step();
            cyc++;
        end
        checks++; if (got != n) begin errors++; $display("FAIL w%0d_kind%0d_delivered: got %0d expected %0d", w, kind, got, n); end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (o_vld === 1'b1) extra++;
            step();
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL w%0d_kind%0d_extra: got %0d expected 0", w, kind, extra); end
    endtask

    task automatic test_midflight_reset(input int k);
        int w = width_of(k);
        int seen = 0;
        sel = k;
        step();
        in_valid = 1'b1; out_ready = 1'b0; in_mode = 1'($urandom_range(0, 1));
        in_data = gen_data(w, in_mode);
        step();
        in_data = gen_data(w, in_mode);
        step();
        @(negedge clk);
        checks++; if (o_vld !== 1'b1 || o_rdy !== 1'b0) begin
            errors++; $display("FAIL w%0d_prefill: got valid=%b ready=%b expected valid=1 ready=0", w, o_vld, o_rdy);
        end
        rst = 1'b1;
        step();
        checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL w%0d_rst_valid: got %b expected 0", w, o_vld); end
        checks++; if (o_cnt !== 0 || o_norm !== 64'd0) begin errors++; $display("FAIL w%0d_rst_data: got cnt=%0d norm=%h expected 0", w, o_cnt, o_norm); end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (o_vld === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL w%0d_stale: got %0d outputs expected 0", w, seen); end
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_mode = 1'b0; in_data = '0; sel = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_stream(0, 1, 32);
        for (int k = 0; k < 3; k++) test_stream(k, 0, 200);
        for (int k = 0; k < 3; k++) test_midflight_reset(k);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
